// File: rtl/mips_mc_pkg.sv
// Shared state encoding, opcode/funct constants and control bundle for the multicycle MIPS controller.
// Pure declarations: no latency, no flow control.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    ADDIEX,
    ADDIWB,
    JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/ALUDecoder.sv
// Maps aluop and the R-type funct field to the 3-bit ALU operation.
// Combinational, zero latency; no flow control.
module ALUDecoder
  import mips_mc_pkg::*;
(
  input  logic [5:0] i_funct,
  input  logic [1:0] i_aluop,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALUC_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALUC_ADD;
      ALUOP_SUB: o_alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALUC_ADD;
          FN_SUB:  o_alucontrol = ALUC_SUB;
          FN_AND:  o_alucontrol = ALUC_AND;
          FN_OR:   o_alucontrol = ALUC_OR;
          FN_SLT:  o_alucontrol = ALUC_SLT;
          default: o_alucontrol = ALUC_ADD;
        endcase
      end
      default: o_alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_output_decode.sv
// State-to-control decode for the multicycle controller; mem_ready only gates the FETCH loads.
// Combinational, zero latency; stalls are expressed by the caller holding state.
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_op,
  input  logic       i_mem_rdy,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.pcsrc   = PCSRC_ALU;
        o_ctrl.irwrite = i_mem_rdy;
        o_ctrl.pcwrite = i_mem_rdy;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        o_ctrl.alusrcb    = SRCB_IMM_SH2;
        o_ctrl.aluop      = ALUOP_ADD;
        o_ctrl.illegal_op = ~is_legal_op(i_op);
      end
      MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        o_ctrl.iord = 1'b1;
      end
      MEMWB: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REG;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REG;
        o_ctrl.aluop   = ALUOP_SUB;
        o_ctrl.pcsrc   = PCSRC_ALUOUT;
        o_ctrl.branch  = 1'b1;
      end
      ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      ADDIWB: begin
        o_ctrl.regwrite = 1'b1;
      end
      JEX: begin
        o_ctrl.pcsrc   = PCSRC_JUMP;
        o_ctrl.pcwrite = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for lw, sw, R-type, beq, addi, j.
// beq/j 3 cycles, R-type/addi/sw 4, lw 5 with mem_ready high; each cycle of mem_ready low in FETCH/MEMRD/MEMWR adds one.
module multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       memwrite,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t     r_state;
  ctrl_t      w_ctrl;
  logic       w_mem_rdy;
  logic       w_known;
  logic [2:0] w_alucontrol;

  assign w_mem_rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:   if (w_mem_rdy) r_state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_RTYPE:     r_state <= RTYPEEX;
            OP_BEQ:       r_state <= BEQEX;
            OP_ADDI:      r_state <= ADDIEX;
            OP_J:         r_state <= JEX;
            default:      r_state <= FETCH;
          endcase
        end
        MEMADR:  r_state <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (w_mem_rdy) r_state <= MEMWB;
        MEMWB:   r_state <= FETCH;
        MEMWR:   if (w_mem_rdy) r_state <= FETCH;
        RTYPEEX: r_state <= RTYPEWB;
        RTYPEWB: r_state <= FETCH;
        BEQEX:   r_state <= FETCH;
        ADDIEX:  r_state <= ADDIWB;
        ADDIWB:  r_state <= FETCH;
        JEX:     r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

  mc_output_decode u_output_decode (
    .i_state   (r_state),
    .i_op      (op),
    .i_mem_rdy (w_mem_rdy),
    .o_ctrl    (w_ctrl)
  );

  ALUDecoder u_alu_decoder (
    .i_funct      (funct),
    .i_aluop      (w_ctrl.aluop),
    .o_alucontrol (w_alucontrol)
  );

  // Unused encodings must drive all-zero, but aluop 00 would otherwise decode to add.
  assign w_known = (r_state <= JEX);

  // Write strobes are gated by reset directly so nothing commits after it asserts.
  assign iord       = w_ctrl.iord;
  assign irwrite    = reset & w_ctrl.irwrite;
  assign pcen       = reset & (w_ctrl.pcwrite | (w_ctrl.branch & zero));
  assign alusrca    = w_ctrl.alusrca;
  assign alusrcb    = w_ctrl.alusrcb;
  assign pcsrc      = w_ctrl.pcsrc;
  assign regdst     = w_ctrl.regdst;
  assign memtoreg   = w_ctrl.memtoreg;
  assign regwrite   = reset & w_ctrl.regwrite;
  assign memwrite   = reset & w_ctrl.memwrite;
  assign illegal_op = reset & w_ctrl.illegal_op;
  assign alucontrol = w_known ? w_alucontrol : 3'b000;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expected state/control traces are queued, then compared cycle by cycle.
module tb_multicycle_controller;
  import mips_mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'h23;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       iord, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, memwrite, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    state_t st;
    logic   mr;
  } step_t;

  step_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_word();
    return {iord, irwrite, pcen, alusrca, alusrcb, pcsrc, regdst, memtoreg,
            regwrite, memwrite, alucontrol, illegal_op};
  endfunction

  // Reference control word, written straight from the per-state output table.
  function automatic logic [15:0] exp_ctrl(input state_t s, input logic mr, input logic z,
                                           input logic [5:0] o, input logic [5:0] fn);
    logic       e_iord = 1'b0, e_irw = 1'b0, e_pcen = 1'b0, e_asa = 1'b0;
    logic       e_rdst = 1'b0, e_m2r = 1'b0, e_rw = 1'b0, e_mw = 1'b0, e_ill = 1'b0;
    logic [1:0] e_asb = 2'b00, e_psrc = 2'b00;
    logic [2:0] e_alc = 3'b010;
    case (s)
      FETCH:   begin e_asb = 2'b01; e_irw = mr; e_pcen = mr; end
      DECODE:  begin
        e_asb = 2'b11;
        e_ill = !(o inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02});
      end
      MEMADR:  begin e_asa = 1'b1; e_asb = 2'b10; end
      MEMRD:   e_iord = 1'b1;
      MEMWB:   begin e_m2r = 1'b1; e_rw = 1'b1; end
      MEMWR:   begin e_iord = 1'b1; e_mw = 1'b1; end
      RTYPEEX: begin
        e_asa = 1'b1;
        case (fn)
          6'h20:   e_alc = 3'b010;
          6'h22:   e_alc = 3'b110;
          6'h24:   e_alc = 3'b000;
          6'h25:   e_alc = 3'b001;
          6'h2a:   e_alc = 3'b111;
          default: e_alc = 3'b010;
        endcase
      end
      RTYPEWB: begin e_rdst = 1'b1; e_rw = 1'b1; end
      BEQEX:   begin e_asa = 1'b1; e_alc = 3'b110; e_psrc = 2'b01; e_pcen = z; end
      ADDIEX:  begin e_asa = 1'b1; e_asb = 2'b10; end
      ADDIWB:  e_rw = 1'b1;
      JEX:     begin e_psrc = 2'b10; e_pcen = 1'b1; end
      default: e_alc = 3'b000;
    endcase
    return {e_iord, e_irw, e_pcen, e_asa, e_asb, e_psrc, e_rdst, e_m2r,
            e_rw, e_mw, e_alc, e_ill};
  endfunction

  function automatic step_t mk(input state_t s, input logic mr);
    step_t t;
    t.st = s;
    t.mr = mr;
    return t;
  endfunction

  // Starts #1 after a posedge with the DUT in FETCH; ends #1 after the edge that returns it to FETCH.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] fn,
                           input logic z, input int fwait, input int mwait);
    step_t e;
    int    got_mw, got_rw, exp_mw, exp_rw;
    op = o;
    funct = fn;
    zero = z;
    for (int i = 0; i < fwait; i++) exp_q.push_back(mk(FETCH, 1'b0));
    exp_q.push_back(mk(FETCH, 1'b1));
    exp_q.push_back(mk(DECODE, 1'b1));
    case (o)
      6'h23: begin
        exp_q.push_back(mk(MEMADR, 1'b1));
        for (int i = 0; i < mwait; i++) exp_q.push_back(mk(MEMRD, 1'b0));
        exp_q.push_back(mk(MEMRD, 1'b1));
        exp_q.push_back(mk(MEMWB, 1'b1));
      end
      6'h2b: begin
        exp_q.push_back(mk(MEMADR, 1'b1));
        for (int i = 0; i < mwait; i++) exp_q.push_back(mk(MEMWR, 1'b0));
        exp_q.push_back(mk(MEMWR, 1'b1));
      end
      6'h00: begin exp_q.push_back(mk(RTYPEEX, 1'b1)); exp_q.push_back(mk(RTYPEWB, 1'b1)); end
      6'h04: exp_q.push_back(mk(BEQEX, 1'b1));
      6'h08: begin exp_q.push_back(mk(ADDIEX, 1'b1)); exp_q.push_back(mk(ADDIWB, 1'b1)); end
      6'h02: exp_q.push_back(mk(JEX, 1'b1));
      default: ;
    endcase
    exp_rw = (o inside {6'h23, 6'h00, 6'h08}) ? 1 : 0;
    exp_mw = (o == 6'h2b) ? mwait + 1 : 0;
    got_mw = 0;
    got_rw = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = e.mr;
      @(negedge clk);
      check_eq({name, "/state"}, 32'(state_o), 32'(e.st));
      check_eq({name, "/ctrl"}, 32'(dut_word()), 32'(exp_ctrl(e.st, e.mr, z, o, fn)));
      got_mw += int'(memwrite);
      got_rw += int'(regwrite);
      @(posedge clk);
      #1;
    end
    check_eq({name, "/back_to_fetch"}, 32'(state_o), 32'(FETCH));
    check_eq({name, "/memwrite_cycles"}, 32'(got_mw), 32'(exp_mw));
    check_eq({name, "/regwrite_cycles"}, 32'(got_rw), 32'(exp_rw));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst/state", 32'(state_o), 32'(FETCH));
    check_eq("rst/ctrl", 32'(dut_word()), 32'(exp_ctrl(FETCH, 1'b0, 1'b0, op, funct)));
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr("lw",         6'h23, 6'h00, 1'b0, 0, 0);
    run_instr("rtype_slt",  6'h00, 6'h2a, 1'b0, 0, 0);
    run_instr("rtype_sub",  6'h00, 6'h22, 1'b0, 0, 0);
    run_instr("rtype_and",  6'h00, 6'h24, 1'b0, 0, 0);
    run_instr("rtype_dflt", 6'h00, 6'h07, 1'b0, 0, 0);
    run_instr("beq_taken",  6'h04, 6'h00, 1'b1, 0, 0);
    run_instr("beq_not",    6'h04, 6'h00, 1'b0, 0, 0);
    run_instr("sw_wait",    6'h2b, 6'h00, 1'b0, 2, 3);
    run_instr("addi",       6'h08, 6'h00, 1'b0, 1, 0);
    run_instr("j",          6'h02, 6'h00, 1'b0, 0, 0);
    run_instr("illegal",    6'h3f, 6'h00, 1'b0, 0, 0);
    run_instr("lw_wait",    6'h23, 6'h25, 1'b0, 1, 2);

    // Asynchronous reset landing in MEMWB.
    op = 6'h23;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("arst/pre_state", 32'(state_o), 32'(MEMWB));
    check_eq("arst/pre_regwrite", 32'(regwrite), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst/state", 32'(state_o), 32'(FETCH));
    check_eq("arst/ctrl", 32'(dut_word()), 32'(exp_ctrl(FETCH, 1'b0, 1'b0, op, funct)));
    @(posedge clk);
    #1;
    check_eq("arst/hold", 32'(state_o), 32'(FETCH));
    reset = 1'b1;
    run_instr("j_after_rst", 6'h02, 6'h00, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Finite-state control unit for the multicycle MIPS datapath. Instructions share one memory, one ALU and one register file across several cycles instead of using separate single-cycle paths. The block sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, beq, addi and j. It stalls on a memory-ready handshake and generates every datapath select and enable.

Parameters:
MEM_WAIT_EN, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored and treated as 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
iord  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory
irwrite  out  1  load instruction register
pcen  out  1  PC load enable
alusrca  out  1  0 = PC; 1 = register A
alusrcb  out  2  00 = B; 01 = 4; 10 = signimm; 11 = signimm<<2
pcsrc  out  2  00 = ALUResult; 01 = ALUOut; 10 = jump target
regdst  out  1  0 = rt; 1 = rd
memtoreg  out  1  0 = ALUOut; 1 = Data register
regwrite  out  1  register file write enable
memwrite  out  1  memory write enable
alucontrol  out  3  ALU operation
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
state_o  out  4  current state, for debug and the bench

Behaviour:
- Moore FSM. State register resets asynchronously to FETCH. All outputs except pcen decode from the state alone. pcen = pcwrite | (branch & zero).
- While reset is low: irwrite, pcen, regwrite, memwrite and illegal_op are forced to 0. Every other output shows its FETCH value.
- aluop encoding: 00 = add (010); 01 = sub (110); 10 = by funct.
  - funct 100000 → 010; 100010 → 110; 100100 → 000; 100101 → 001; 101010 → 111.
  - Any other funct → 010.
- Outputs not listed for a state are 0.
- FETCH: iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite = pcwrite = mem_ready.
  - Go to DECODE on mem_ready; otherwise hold. PC and IR change only in the ready cycle.
- DECODE: alusrca = 0, alusrcb = 11, aluop = 00 (branch target into ALUOut). Next state by op:
  - 100011 / 101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - any other op → FETCH with illegal_op = 1
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. op = 100011 → MEMRD; otherwise → MEMWR.
- MEMRD: iord = 1. mem_ready → MEMWB; otherwise hold.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1 → FETCH.
- MEMWR: iord = 1, memwrite = 1 every waiting cycle. mem_ready → FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, aluop = 10 → RTYPEWB.
- RTYPEWB: regdst = 1, memtoreg = 0, regwrite = 1 → FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, branch = 1 → FETCH. pcen = zero.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00 → ADDIWB.
- ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1 → FETCH.
- JEX: pcsrc = 10, pcwrite = 1 → FETCH.
- Latency with mem_ready tied to 1:
  - beq and j: 3 cycles
  - R-type, addi and sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle adds 1.
- Unused state encodings → FETCH on the next edge. Outputs in an unused state are all 0.
- Reset mid-instruction: state returns to FETCH immediately (asynchronous). No partial write may occur after reset asserts.
- op/funct are sampled only in DECODE, RTYPEEX and MEMADR. The IR is stable in those states.

Decomposition:
- Package mips_mc_pkg holds:
  - state_t enum, 4 bits, in the order FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - aluop constants
- Sub-modules:
  - Instantiate the team's existing ALUDecoder (funct, aluop → alucontrol).
  - The state-to-control decode stays in mc_output_decode, a combinational sub-module.

Test Plan:
- reset = 0 for 2 cycles, then reset = 1 with op = 100011 and mem_ready = 1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite = 1 and memtoreg = 1 only in MEMWB.
- R-type with funct = 101010 → alucontrol = 111 in RTYPEEX. RTYPEWB has regdst = 1 and regwrite = 1. 4 cycles total.
- beq run twice, with zero = 1 and then zero = 0 → pcen = 1 and pcsrc = 01 in BEQEX for the first run; pcen = 0 for the second.
- sw with mem_ready low for 3 cycles in MEMWR → memwrite = 1 for 4 cycles, then FETCH. FETCH with mem_ready low for 2 cycles → irwrite = pcen = 0 until ready.
- op = 111111 → illegal_op pulses for 1 cycle in DECODE, next state FETCH, no regwrite or memwrite.
- reset asserted in MEMWB → state_o = FETCH the same cycle, and regwrite = 0 immediately.
